pe_imem_loader: RTL

- Bus-side load controller for the PE instruction memory. Accepts a load command (base address, word count) and a streamed instruction-word source. Writes the words sequentially through the memory's bus port, one word per cycle.
- Holds the PE core off instruction fetch while a load is in progress.
- Sits between the system bus/DMA and port A of the PE instruction memory.
- Can optionally read back and checksum-verify the loaded range before reporting done.

---
 rtl/pe_imem_loader.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/pe_imem_loader.sv
// Bus-side loader for the PE instruction memory: streams a command's words into port A
// and holds the core off fetch meanwhile. Define PE_IMEM_LOADER_VERIFY_EN for checksum readback.
module pe_imem_loader #(
  parameter int DATA_WIDTH = 28,
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  iClk,
  input  logic                  iReset_n,
  input  logic                  iCmd_Valid,
  output logic                  oCmd_Ready,
  input  logic [ADDR_WIDTH-1:0] iCmd_Base_Addr,
  input  logic [ADDR_WIDTH:0]   iCmd_Length,
  input  logic                  iAbort,
  input  logic                  iData_Valid,
  output logic                  oData_Ready,
  input  logic [DATA_WIDTH-1:0] iData,
  output logic                  oBus_Valid,
  output logic [ADDR_WIDTH-1:0] oBus_Address,
  output logic [DATA_WIDTH-1:0] oBus_Write_Data,
  output logic                  oBus_Write_Enable,
  input  logic [DATA_WIDTH-1:0] iBus_Read_Data,
  output logic                  oCore_Hold,
  output logic                  oBusy,
  output logic                  oDone,
  output logic                  oError,
  output logic [ADDR_WIDTH:0]   oWord_Count
);

  typedef enum logic [2:0] {IDLE, LOAD, VERIFY, VCHK, DONE} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] base_reg;
  logic [ADDR_WIDTH:0]   length_reg;
  logic [ADDR_WIDTH:0]   word_count_reg;
  logic [DATA_WIDTH-1:0] checksum_reg;
  logic                  error_reg;

  logic cmd_accept;
  logic beat;
  logic last_beat;
  logic abort_hit;

  assign cmd_accept = (state_reg == IDLE) && iCmd_Valid;
  assign beat       = (state_reg == LOAD) && iData_Valid && !iAbort;
  assign last_beat  = beat && ((word_count_reg + 1'b1) == length_reg);
  assign abort_hit  = iAbort && ((state_reg == LOAD) || (state_reg == VERIFY) || (state_reg == VCHK));

`ifdef PE_IMEM_LOADER_VERIFY_EN
  logic [ADDR_WIDTH:0]   rd_idx_reg;
  logic [DATA_WIDTH-1:0] readback_reg;
  logic                  last_read;
  logic                  verify_ok;

  assign last_read = (rd_idx_reg + 1'b1) == length_reg;
  // The final read word arrives during VCHK, so fold it in combinationally for the compare.
  assign verify_ok = (readback_reg ^ iBus_Read_Data) == checksum_reg;
`else
  logic unused_read_data;
  assign unused_read_data = ^iBus_Read_Data;
`endif

  always_comb begin
    state_next        = state_reg;
    oData_Ready       = 1'b0;
    oBus_Valid        = 1'b0;
    oBus_Write_Enable = 1'b0;
    oBus_Address      = '0;
    oBus_Write_Data   = '0;
    case (state_reg)
      IDLE: begin
        if (iCmd_Valid) begin
          state_next = (iCmd_Length == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        oData_Ready = !iAbort;
        if (iAbort) begin
          state_next = IDLE;
        end else if (iData_Valid) begin
          oBus_Valid        = 1'b1;
          oBus_Write_Enable = 1'b1;
          oBus_Address      = base_reg + word_count_reg[ADDR_WIDTH-1:0];
          oBus_Write_Data   = iData;
          if (last_beat) begin
`ifdef PE_IMEM_LOADER_VERIFY_EN
            state_next = VERIFY;
`else
            state_next = DONE;
`endif
          end
        end
      end
`ifdef PE_IMEM_LOADER_VERIFY_EN
      VERIFY: begin
        if (iAbort) begin
          state_next = IDLE;
        end else begin
          oBus_Valid   = 1'b1;
          oBus_Address = base_reg + rd_idx_reg[ADDR_WIDTH-1:0];
          if (last_read) begin
            state_next = VCHK;
          end
        end
      end
      VCHK: begin
        if (iAbort) begin
          state_next = IDLE;
        end else begin
          state_next = verify_ok ? DONE : IDLE;
        end
      end
`endif
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state_reg      <= IDLE;
      base_reg       <= '0;
      length_reg     <= '0;
      word_count_reg <= '0;
      checksum_reg   <= '0;
      error_reg      <= 1'b0;
`ifdef PE_IMEM_LOADER_VERIFY_EN
      rd_idx_reg     <= '0;
      readback_reg   <= '0;
`endif
    end else begin
      state_reg <= state_next;
      if (cmd_accept) begin
        base_reg       <= iCmd_Base_Addr;
        length_reg     <= iCmd_Length;
        word_count_reg <= '0;
        checksum_reg   <= '0;
        error_reg      <= 1'b0;
`ifdef PE_IMEM_LOADER_VERIFY_EN
        rd_idx_reg     <= '0;
        readback_reg   <= '0;
`endif
      end
      if (beat) begin
        word_count_reg <= word_count_reg + 1'b1;
        checksum_reg   <= checksum_reg ^ iData;
      end
      if (abort_hit) begin
        error_reg <= 1'b1;
      end
`ifdef PE_IMEM_LOADER_VERIFY_EN
      // Read data lags its request by one cycle; the first VERIFY cycle has nothing to absorb.
      if ((state_reg == VERIFY) && !iAbort) begin
        rd_idx_reg <= rd_idx_reg + 1'b1;
        if (rd_idx_reg != '0) begin
          readback_reg <= readback_reg ^ iBus_Read_Data;
        end
      end
      if ((state_reg == VCHK) && !iAbort && !verify_ok) begin
        error_reg <= 1'b1;
      end
`endif
    end
  end

  assign oCmd_Ready  = (state_reg == IDLE);
  assign oBusy       = (state_reg != IDLE);
  assign oCore_Hold  = oBusy;
  assign oDone       = (state_reg == DONE);
  assign oError      = error_reg;
  assign oWord_Count = word_count_reg;

endmodule
